rf_mp: RTL and testbench



---
 rtl/rf_pkg.sv | 26 ++
 rtl/rf_scoreboard.sv | 61 ++++++
 rtl/rf_mp.sv | 109 ++++++++++
 tb/tb_rf_mp.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Holds the packed-slice extractor used to split the read-index vector per port.
package rf_pkg;

   localparam int unsigned XLEN_D   = 32'd32;
   localparam int unsigned NREG_D   = 32'd32;
   localparam int unsigned NRD_D    = 32'd2;
   localparam int unsigned REG_ZERO = 32'd0;

   // Widest packed vector and widest field the slice helper can handle.
   localparam int unsigned SLICE_VW = 32'd256;
   localparam int unsigned SLICE_W  = 32'd64;

   function automatic logic [SLICE_W-1:0] slice_get(
      input logic [SLICE_VW-1:0] vec,
      input int unsigned         idx,
      input int unsigned         w
   );
      logic [SLICE_VW-1:0] sh;
      logic [SLICE_VW-1:0] msk;
      sh  = vec >> (idx * w);
      msk = ~({SLICE_VW{1'b1}} << w);
      slice_get = sh[SLICE_W-1:0] & msk[SLICE_W-1:0];
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard with flush > issue-set > write-clear priority.
// Register 0 is never busy.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int unsigned NREG = NREG_D,
   parameter int unsigned AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            iss_v,
   input  logic [AW-1:0]   iss_rd,
   input  logic            we0,
   input  logic [AW-1:0]   wR0,
   input  logic            we1,
   input  logic [AW-1:0]   wR1,
   input  logic            flush,
   output logic [NREG-1:0] busy,
   output logic            any_busy
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic            any_busy_q;
   logic            any_busy_d;

   // Next-state busy vector
   always_comb begin
      busy_d = busy_q;
      if (flush) begin
         busy_d = '0;
      end else begin
         for (int r = 1; r < int'(NREG); r++) begin
            if (iss_v && (iss_rd == AW'(r))) begin
               busy_d[r] = 1'b1;
            end else if ((we0 && (wR0 == AW'(r))) || (we1 && (wR1 == AW'(r)))) begin
               busy_d[r] = 1'b0;
            end else begin
               busy_d[r] = busy_q[r];
            end
         end
      end
      busy_d[REG_ZERO] = 1'b0;
      any_busy_d = |busy_d;
   end

   // Busy state and its registered OR-reduction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q     <= '0;
         any_busy_q <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         any_busy_q <= any_busy_d;
      end
   end

   assign busy     = busy_q;
   assign any_busy = any_busy_q;

endmodule

// File: rtl/rf_mp.sv
// Multi-port integer register file: NRD combinational read ports, two write ports, busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data to the read ports.
module rf_mp
   import rf_pkg::*;
#(
   parameter  int unsigned XLEN = XLEN_D,
   parameter  int unsigned NREG = NREG_D,
   parameter  int unsigned NRD  = NRD_D,
   localparam int unsigned AW   = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRD*AW-1:0]   rR,
   output logic [NRD*XLEN-1:0] rD,
   output logic [NRD-1:0]      rBusy,
   input  logic                we0,
   input  logic [AW-1:0]       wR0,
   input  logic [XLEN-1:0]     wD0,
   input  logic                we1,
   input  logic [AW-1:0]       wR1,
   input  logic [XLEN-1:0]     wD1,
   input  logic                iss_v,
   input  logic [AW-1:0]       iss_rd,
   input  logic                flush,
   output logic                any_busy
);

   logic [XLEN-1:0]     mem_q [NREG];
   logic [XLEN-1:0]     mem_d [NREG];
   logic [NREG-1:0]     busy_s;
   logic [SLICE_VW-1:0] rr_ext_s;
   logic [AW-1:0]       ridx_s [NRD];

   rf_scoreboard #(
      .NREG (NREG),
      .AW   (AW)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .iss_v    (iss_v),
      .iss_rd   (iss_rd),
      .we0      (we0),
      .wR0      (wR0),
      .we1      (we1),
      .wR1      (wR1),
      .flush    (flush),
      .busy     (busy_s),
      .any_busy (any_busy)
   );

   // Write merge: port 1 overrides port 0 on the same index; entry 0 stays zero
   always_comb begin
      for (int r = 0; r < int'(NREG); r++) begin
         mem_d[r] = mem_q[r];
      end
      for (int r = 1; r < int'(NREG); r++) begin
         if (we1 && (wR1 == AW'(r))) begin
            mem_d[r] = wD1;
         end else if (we0 && (wR0 == AW'(r))) begin
            mem_d[r] = wD0;
         end else begin
            mem_d[r] = mem_q[r];
         end
      end
      mem_d[REG_ZERO] = '0;
   end

   // Register array
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < int'(NREG); r++) begin
            mem_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < int'(NREG); r++) begin
            mem_q[r] <= mem_d[r];
         end
      end
   end

   // Combinational read muxes (optionally with same-cycle write forwarding)
   always_comb begin
      rr_ext_s = '0;
      rr_ext_s[NRD*AW-1:0] = rR;
      rD    = '0;
      rBusy = '0;
      for (int unsigned i = 0; i < NRD; i++) begin
         ridx_s[i] = AW'(slice_get(rr_ext_s, i, AW));
         rD[i*XLEN +: XLEN] = mem_q[ridx_s[i]];
         rBusy[i]           = busy_s[ridx_s[i]];
`ifdef RF_BYPASS_EN
         if (rst_n && (ridx_s[i] != AW'(REG_ZERO))) begin
            if (we1 && (wR1 == ridx_s[i])) begin
               rD[i*XLEN +: XLEN] = wD1;
               rBusy[i]           = 1'b0;
            end else if (we0 && (wR0 == ridx_s[i])) begin
               rD[i*XLEN +: XLEN] = wD0;
               rBusy[i]           = 1'b0;
            end else begin
               rBusy[i] = busy_s[ridx_s[i]];
            end
         end else begin
            rBusy[i] = busy_s[ridx_s[i]];
         end
`endif
      end
   end

endmodule

// File: tb/tb_rf_mp.sv
// Self-checking bench for rf_mp: behavioural model compared every cycle plus directed literal checks.
// Honours RF_BYPASS_EN for the bypass-dependent expectations.
module tb_rf_mp;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int AW   = 5;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NRD*AW-1:0]   rR;
   logic [NRD*XLEN-1:0] rD;
   logic [NRD-1:0]      rBusy;
   logic                we0, we1, iss_v, flush;
   logic [AW-1:0]       wR0, wR1, iss_rd;
   logic [XLEN-1:0]     wD0, wD1;
   logic                any_busy;

   int n_checks = 0;
   int n_errors = 0;

   rf_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
      .clk(clk), .rst_n(rst_n), .rR(rR), .rD(rD), .rBusy(rBusy),
      .we0(we0), .wR0(wR0), .wD0(wD0), .we1(we1), .wR1(wR1), .wD1(wD1),
      .iss_v(iss_v), .iss_rd(iss_rd), .flush(flush), .any_busy(any_busy)
   );

   always #5 clk = ~clk;

   // Architectural model: register values and pending-write flags
   logic [XLEN-1:0] m_reg  [NREG];
   logic            m_busy [NREG];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            m_reg[r]  <= '0;
            m_busy[r] <= 1'b0;
         end
      end else begin
         if (we0 && wR0 != 0) m_reg[wR0] <= wD0;
         if (we1 && wR1 != 0) m_reg[wR1] <= wD1;
         if (flush) begin
            for (int r = 0; r < NREG; r++) m_busy[r] <= 1'b0;
         end else begin
            if (we0) m_busy[wR0] <= 1'b0;
            if (we1) m_busy[wR1] <= 1'b0;
            if (iss_v && iss_rd != 0) m_busy[iss_rd] <= 1'b1;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [AW-1:0]   idx;
      logic [XLEN-1:0] ed;
      logic            eb;
      logic            ea;
      ea = 1'b0;
      for (int r = 0; r < NREG; r++) ea = ea | m_busy[r];
      chk("any_busy", 64'(any_busy), 64'(ea));
      for (int p = 0; p < NRD; p++) begin
         idx = rR[p*AW +: AW];
         ed  = (idx == 0) ? '0 : m_reg[idx];
         eb  = (idx == 0) ? 1'b0 : m_busy[idx];
`ifdef RF_BYPASS_EN
         if (rst_n === 1'b1 && idx != 0) begin
            if (we1 && wR1 == idx) begin
               ed = wD1; eb = 1'b0;
            end else if (we0 && wR0 == idx) begin
               ed = wD0; eb = 1'b0;
            end
         end
`endif
         chk($sformatf("rD[%0d]", p), 64'(rD[p*XLEN +: XLEN]), 64'(ed));
         chk($sformatf("rBusy[%0d]", p), 64'(rBusy[p]), 64'(eb));
      end
   endtask

   task automatic idle();
      we0 = 1'b0; wR0 = '0; wD0 = '0;
      we1 = 1'b0; wR1 = '0; wD1 = '0;
      iss_v = 1'b0; iss_rd = '0; flush = 1'b0;
   endtask

   task automatic nxt();
      @(negedge clk);
      idle();
   endtask

   function automatic logic [NRD*AW-1:0] rd_idx(input int a, input int b);
      logic [AW-1:0] ia;
      logic [AW-1:0] ib;
      ia = AW'(a);
      ib = AW'(b);
      return {ib, ia};
   endfunction

   logic cmp_en = 1'b0;

   initial begin
      rst_n = 1'b1;
      idle();
      rR = '0;
      fork
         begin
            forever begin
               @(negedge clk);
               #3;
               if (cmp_en) compare_all();
            end
         end
         begin
            #1;
            rst_n = 1'b0;
            we1 = 1'b1; wR1 = 5'd5; wD1 = 32'hDEADBEEF;
            rR = rd_idx(5, 0);
            cmp_en = 1'b1;
            repeat (2) begin
               @(negedge clk); #4;
               chk("reset_rd", 64'(rD[31:0]), 64'h0);
               chk("reset_any", 64'(any_busy), 64'h0);
            end
            nxt(); rst_n = 1'b1; rR = rd_idx(5, 0);
            #4 chk("post_reset_r5", 64'(rD[31:0]), 64'h0);
            chk("post_reset_busy", 64'(rBusy), 64'h0);

            nxt(); we1 = 1'b1; wR1 = 5'd3; wD1 = 32'h12345678; rR = rd_idx(3, 0);
            nxt(); rR = rd_idx(3, 0);
            #4 chk("r3_read", 64'(rD[31:0]), 64'h12345678);

            nxt(); we1 = 1'b1; wR1 = 5'd0; wD1 = 32'hFFFFFFFF;
            we0 = 1'b1; wR0 = 5'd0; wD0 = 32'hFFFFFFFF;
            nxt(); rR = rd_idx(0, 0);
            #4 chk("r0_read", 64'(rD), 64'h0);

            nxt(); we0 = 1'b1; we1 = 1'b1; wR0 = 5'd7; wR1 = 5'd7;
            wD0 = 32'h0000AAAA; wD1 = 32'h0000BBBB;
            nxt(); rR = rd_idx(7, 3);
            #4 chk("dual_r7", 64'(rD[31:0]), 64'h0000BBBB);
            chk("dual_r3", 64'(rD[63:32]), 64'h12345678);

            nxt(); iss_v = 1'b1; iss_rd = 5'd9; rR = rd_idx(9, 0);
            #4 chk("iss_same_cycle", 64'(rBusy[0]), 64'h0);
            nxt();
            #4 chk("busy_r9", 64'(rBusy[0]), 64'h1);
            chk("any_busy_r9", 64'(any_busy), 64'h1);
            nxt(); we1 = 1'b1; wR1 = 5'd9; wD1 = 32'h99;
            nxt();
            #4 chk("clear_r9", 64'(rBusy[0]), 64'h0);
            chk("clear_any", 64'(any_busy), 64'h0);
            nxt(); iss_v = 1'b1; iss_rd = 5'd9; we1 = 1'b1; wR1 = 5'd9; wD1 = 32'h9A;
            nxt();
            #4 chk("set_wins", 64'(rBusy[0]), 64'h1);
            nxt(); we0 = 1'b1; wR0 = 5'd9; wD0 = 32'h9B;

            nxt(); iss_v = 1'b1; iss_rd = 5'd4;
            nxt(); iss_v = 1'b1; iss_rd = 5'd12; rR = rd_idx(4, 12);
            nxt(); rR = rd_idx(4, 12);
            #4 chk("busy_4_12", 64'(rBusy), 64'h3);
            nxt(); flush = 1'b1; iss_v = 1'b1; iss_rd = 5'd6;
            nxt(); rR = rd_idx(6, 12);
            #4 chk("flush_busy", 64'(rBusy), 64'h0);
            chk("flush_any", 64'(any_busy), 64'h0);
            nxt(); iss_v = 1'b1; iss_rd = 5'd0;
            nxt(); rR = rd_idx(0, 0);
            #4 chk("iss_r0_ignored", 64'(any_busy), 64'h0);

            nxt(); we0 = 1'b1; wR0 = 5'd2; wD0 = 32'h1;
            nxt(); we1 = 1'b1; wR1 = 5'd2; wD1 = 32'h55; rR = rd_idx(2, 0);
`ifdef RF_BYPASS_EN
            #4 chk("bypass_same", 64'(rD[31:0]), 64'h55);
            chk("bypass_busy", 64'(rBusy[0]), 64'h0);
`else
            #4 chk("nobypass_same", 64'(rD[31:0]), 64'h1);
`endif
            nxt(); rR = rd_idx(2, 0);
            #4 chk("after_write_r2", 64'(rD[31:0]), 64'h55);

            nxt(); we1 = 1'b1; wR1 = 5'd3; wD1 = 32'hCAFEF00D; rR = rd_idx(3, 2);
            #2 rst_n = 1'b0;
            #2 chk("midreset_r3", 64'(rD), 64'h0);
            nxt(); rst_n = 1'b1; rR = rd_idx(3, 2);
            #4 chk("midreset_lost", 64'(rD), 64'h0);

            for (int k = 0; k < 300; k++) begin
               nxt();
               rR     = (NRD*AW)'($urandom);
               we0    = 1'($urandom);  wR0 = AW'($urandom);  wD0 = $urandom;
               we1    = 1'($urandom);  wR1 = AW'($urandom);  wD1 = $urandom;
               if ((k % 3) == 0) wR1 = wR0;
               iss_v  = 1'($urandom);  iss_rd = AW'($urandom);
               flush  = ($urandom_range(0, 15) == 0);
            end
            nxt();
            @(negedge clk);
         end
      join_any
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
